// File: rtl/ex_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs (package)
// Description : Shared types for the EX-stage multiply/divide unit:
//               operation encoding, FSM states and op classification.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_MADD  = 3'd2,
        MD_MADDU = 3'd3,
        MD_MSUB  = 3'd4,
        MD_MSUBU = 3'd5,
        MD_DIV   = 3'd6,
        MD_DIVU  = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    // One bit per op code: set where the operands are two's complement
    localparam logic [7:0] c_signed_op_mask = 8'b0101_0101;
    // One bit per op code: set for the divide class
    localparam logic [7:0] c_div_op_mask    = 8'b1100_0000;

    function automatic logic op_is_signed(input muldiv_op_t op);
        return c_signed_op_mask[op];
    endfunction

    function automatic logic op_is_div(input muldiv_op_t op);
        return c_div_op_mask[op];
    endfunction

    function automatic logic op_is_supported(input muldiv_op_t op);
        case (op)
            MD_MULT, MD_MULTU, MD_MADD, MD_MADDU,
            MD_MSUB, MD_MSUBU, MD_DIV, MD_DIVU: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_divider.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_divider
// Description : Unsigned restoring divider, one quotient bit per cycle.
//               Loads on i_start, runs WIDTH iterations. o_quotient and
//               o_remainder carry the outcome of the iteration in progress,
//               so during the o_done cycle they are the final values.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_done
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_div;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_active;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;

    // One restoring step: shift in the next dividend bit, try the subtract
    always_comb begin
        w_shift     = {r_rem, r_quo[WIDTH-1]};
        w_diff      = w_shift - {1'b0, r_div};
        w_fits      = ~w_diff[WIDTH];
        o_quotient  = {r_quo[WIDTH-2:0], w_fits};
        o_remainder = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        o_done      = r_active && (r_cnt == c_cnt_w'(WIDTH - 1));
    end

    // Operand load, iteration registers and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_flush) begin
            r_active <= 1'b0;
        end else if (i_start) begin
            r_quo    <= i_dividend;
            r_rem    <= '0;
            r_div    <= i_divisor;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_quo <= o_quotient;
            r_rem <= o_remainder;
            if (o_done) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : EX-stage multi-cycle multiply/divide unit. Handles MULT(U),
//               MADD(U), MSUB(U) via an inline multiplier and DIV(U) via an
//               iterative restoring divider; drives the EX stall request.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit
    import cpu_defs::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  muldiv_op_t         op,
    input  logic               flush,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [2*WIDTH-1:0] hilo_in,
    output logic [2*WIDTH-1:0] result,
    output logic               result_valid,
    output logic               busy
);

    // Wide enough for MUL_STAGES up to 4 (counts 0..3)
    localparam int c_mcnt_w = 3;

    muldiv_state_t        r_state;
    muldiv_state_t        w_next_state;

    muldiv_op_t           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_raw_a;
    logic                 r_sa;
    logic                 r_sb;
    logic [2*WIDTH-1:0]   r_hilo;
    logic [c_mcnt_w-1:0]  r_mul_cnt;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_is_signed;
    logic                 w_is_div;
    logic                 w_sa;
    logic                 w_sb;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_accept;
    logic                 w_mul_last;

    logic [2*WIDTH-1:0]   w_mag;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_mul_result;

    logic [WIDTH-1:0]     w_div_q;
    logic [WIDTH-1:0]     w_div_r;
    logic                 w_div_done;
    logic [WIDTH-1:0]     w_div_lo;
    logic [WIDTH-1:0]     w_div_hi;
    logic [2*WIDTH-1:0]   w_div_result;

    // Operand classification and magnitude extraction at issue
    always_comb begin
        w_is_signed = op_is_signed(op);
        w_is_div    = op_is_div(op);
        w_sa        = w_is_signed & src_a[WIDTH-1];
        w_sb        = w_is_signed & src_b[WIDTH-1];
        w_abs_a     = w_sa ? -src_a : src_a;
        w_abs_b     = w_sb ? -src_b : src_b;
        w_accept    = (r_state == ST_IDLE) && start && !flush && op_is_supported(op);
        w_mul_last  = (r_mul_cnt == c_mcnt_w'(MUL_STAGES - 1));
    end

    // Multiplier: magnitude product, sign fix, then optional HI/LO accumulate.
    // Operands stay stable in r_a/r_b for all MUL cycles (multicycle path).
    always_comb begin
        w_mag  = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
        w_prod = (r_sa ^ r_sb) ? -w_mag : w_mag;
        case (r_op)
            MD_MADD, MD_MADDU: w_mul_result = r_hilo + w_prod;
            MD_MSUB, MD_MSUBU: w_mul_result = r_hilo - w_prod;
            default:           w_mul_result = w_prod;
        endcase
    end

    muldiv_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_accept & w_is_div),
        .i_flush     (flush),
        .i_dividend  (w_abs_a),
        .i_divisor   (w_abs_b),
        .o_quotient  (w_div_q),
        .o_remainder (w_div_r),
        .o_done      (w_div_done)
    );

    // Divider sign restoration and the divide-by-zero convention
    always_comb begin
        w_div_lo = (r_sa ^ r_sb) ? -w_div_q : w_div_q;
        w_div_hi = r_sa ? -w_div_r : w_div_r;
        if (r_b == '0) begin
            w_div_lo = '1;
            w_div_hi = r_raw_a;
        end
        w_div_result = {w_div_hi, w_div_lo};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    busy         = 1'b1;
                    w_next_state = w_is_div ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                busy = 1'b1;
                if (flush) begin
                    w_next_state = ST_IDLE;
                end else if (w_mul_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DIV: begin
                busy = 1'b1;
                if (flush) begin
                    w_next_state = ST_IDLE;
                end else if (w_div_done) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                // start is ignored here so a still-held instruction does not re-issue
                result_valid = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Operand capture, MUL stage counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= MD_MULT;
            r_a       <= '0;
            r_b       <= '0;
            r_raw_a   <= '0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_hilo    <= '0;
            r_mul_cnt <= '0;
            r_result  <= '0;
        end else begin
            if (w_accept) begin
                r_op      <= op;
                r_a       <= w_abs_a;
                r_b       <= w_abs_b;
                r_raw_a   <= src_a;
                r_sa      <= w_sa;
                r_sb      <= w_sb;
                r_hilo    <= hilo_in;
                r_mul_cnt <= '0;
            end
            if (r_state == ST_MUL) begin
                r_mul_cnt <= r_mul_cnt + 1'b1;
                if (w_mul_last && !flush) begin
                    r_result <= w_mul_result;
                end
            end
            if ((r_state == ST_DIV) && w_div_done && !flush) begin
                r_result <= w_div_result;
            end
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire
